// File: rtl/mux_rr_nxw.sv
// N-channel to one registered mux with fixed or round-robin grant.
// The output register is a single-entry skid-free stage: a new beat may load on the same edge the old one leaves.
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | output register free, out_valid low
// S_FULL  | output register holds a beat, out_valid high
module mux_rr_nxw #(
   parameter int  N_CH  = 4,
   parameter int  WIDTH = 8,
   localparam int SELW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   input  logic                  mode,
   input  logic [SELW-1:0]       select,
   output logic [WIDTH-1:0]      out_data,
   output logic [SELW-1:0]       out_ch,
   output logic                  out_valid,
   input  logic                  out_ready
);

   typedef enum logic {S_EMPTY, S_FULL} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [SELW-1:0]   r_ptr;
   logic [WIDTH-1:0]  r_out_data;
   logic [SELW-1:0]   r_out_ch;

   logic              w_free;
   logic              w_in_xfer;
   logic              w_fix_ok;
   logic              w_rr_found;
   logic [SELW-1:0]   w_rr_gnt;
   logic              w_gnt_vld;
   logic [SELW-1:0]   w_gnt;
   logic [SELW-1:0]   w_ptr_nxt;
   logic [N_CH-1:0]   w_ready;

   // Fixed mode only grants an in-range select whose channel is actually valid.
   always_comb begin
      w_fix_ok = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (select == SELW'(i) && in_valid[i]) w_fix_ok = 1'b1;
      end
   end

   always_comb begin
      int idx;
      idx        = 0;
      w_rr_found = 1'b0;
      w_rr_gnt   = '0;
      for (int k = 0; k < N_CH; k++) begin
         idx = int'(r_ptr) + k;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!w_rr_found && in_valid[idx]) begin
            w_rr_found = 1'b1;
            w_rr_gnt   = SELW'(idx);
         end
      end
   end

   assign w_gnt     = mode ? w_rr_gnt   : select;
   assign w_gnt_vld = mode ? w_rr_found : w_fix_ok;
   assign w_free    = (r_state == S_EMPTY) || out_ready;
   assign w_ptr_nxt = (int'(w_gnt) == N_CH - 1) ? '0 : w_gnt + SELW'(1);

   // rst_n gates the grant so in_ready stays low throughout reset.
   always_comb begin
      w_ready = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_ready[i] = rst_n && w_gnt_vld && w_free && (w_gnt == SELW'(i));
      end
   end

   assign in_ready  = w_ready;
   assign w_in_xfer = |(in_valid & w_ready);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_EMPTY: if (w_in_xfer) w_state_nxt = S_FULL;
         S_FULL:  if (out_ready && !w_in_xfer) w_state_nxt = S_EMPTY;
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_EMPTY;
         r_ptr      <= '0;
         r_out_data <= '0;
         r_out_ch   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_in_xfer) begin
            r_out_data <= in_data[w_gnt*WIDTH +: WIDTH];
            r_out_ch   <= w_gnt;
            if (mode) r_ptr <= w_ptr_nxt;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;
   assign out_valid = (r_state == S_FULL);

endmodule
